double_to_float: RTL and testbench

//  Multi-cycle IEEE-754 binary64 -> binary32 converter; companion of the FPU's float->double path.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/double_to_float_if.sv | 22 ++
 rtl/fpu_round_unit.sv | 21 ++
 rtl/double_to_float.sv | 172 +++++++++++++++++
 tb/tb_double_to_float.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants, state encoding and flag bundle for the binary64 -> binary32 converter.
package fpu_pkg;

    localparam int F64_EXP_W = 11;
    localparam int F64_MAN_W = 52;
    localparam int F32_EXP_W = 8;
    localparam int F32_MAN_W = 23;
    localparam int F64_BIAS  = 1023;
    localparam int F32_BIAS  = 127;
    localparam int BIAS_DIFF = F64_BIAS - F32_BIAS;

    localparam logic [F64_EXP_W-1:0] F64_EXP_ALL_ONES = '1;
    localparam logic [F32_EXP_W-1:0] F32_EXP_ALL_ONES = '1;

    localparam int RM_RNE = 0;
    localparam int RM_RTZ = 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CONVERT,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic nan;
        logic ovf;
        logic unf;
        logic inx;
    } flags_t;

endpackage

// File: rtl/double_to_float_if.sv
// Request/result bundle between a requester (master) and the double->float converter (slave).
interface double_to_float_if;
    logic        start;
    logic [63:0] dbl;
    logic [31:0] flt;
    logic        busy;
    logic        done;
    logic        nan_exception;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    modport master (
        output start, dbl,
        input  flt, busy, done, nan_exception, overflow, underflow, inexact
    );

    modport slave (
        input  start, dbl,
        output flt, busy, done, nan_exception, overflow, underflow, inexact
    );
endinterface

// File: rtl/fpu_round_unit.sv
// Mantissa rounding from guard/sticky/lsb; shared by the FPU narrowing converters.
module fpu_round_unit
    import fpu_pkg::*;
#(
    parameter int ROUND_MODE = RM_RNE
) (
    input  logic [F32_MAN_W-1:0] i_man,
    input  logic                 i_guard,
    input  logic                 i_sticky,
    input  logic                 i_lsb,
    output logic [F32_MAN_W-1:0] o_man,
    output logic                 o_carry,
    output logic                 o_inexact
);
    logic w_inc;

    // Ties go to even: a bare guard bit only rounds up when the lsb is odd.
    assign w_inc     = (ROUND_MODE == RM_RNE) ? (i_guard & (i_sticky | i_lsb)) : 1'b0;
    assign {o_carry, o_man} = {1'b0, i_man} + {{F32_MAN_W{1'b0}}, w_inc};
    assign o_inexact = i_guard | i_sticky;
endmodule

// File: rtl/double_to_float.sv
// Multi-cycle IEEE-754 binary64 -> binary32 converter (IDLE/CHECK/CONVERT/ROUND/DONE).
// Define DOUBLE_TO_FLOAT_SUBNORMAL_EN to produce float subnormals instead of flushing to zero.
module double_to_float
    import fpu_pkg::*;
#(
    parameter int ROUND_MODE = RM_RNE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    double_to_float_if.slave bus
);
    state_t                 r_state;
    logic [63:0]            r_dbl;
    logic [F32_EXP_W-1:0]   r_exp;
    logic [F32_MAN_W-1:0]   r_man;
    logic                   r_guard;
    logic                   r_sticky;
    logic                   r_tiny;
    logic                   r_bypass;
    logic [31:0]            r_float;
    flags_t                 r_flags;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_s;
    logic [F64_EXP_W-1:0]   w_e;
    logic [F64_MAN_W-1:0]   w_m;
    logic signed [11:0]     w_e32;
    logic [F32_MAN_W-1:0]   w_rman;
    logic                   w_carry;
    logic                   w_inexact;

    assign w_s   = r_dbl[63];
    assign w_e   = r_dbl[62:52];
    assign w_m   = r_dbl[51:0];
    assign w_e32 = $signed({1'b0, w_e}) - 12'sd896;

`ifdef DOUBLE_TO_FLOAT_SUBNORMAL_EN
    logic [11:0] w_sh;
    logic [76:0] w_wide;

    // Hidden bit sits at bit 77 before the shift; field/guard/sticky keep normal-path positions.
    assign w_sh   = 12'd1 - $unsigned(w_e32);
    assign w_wide = 77'({1'b1, w_m, 25'd0} >> w_sh);
`endif

    fpu_round_unit #(.ROUND_MODE(ROUND_MODE)) u_round (
        .i_man     (r_man),
        .i_guard   (r_guard),
        .i_sticky  (r_sticky),
        .i_lsb     (r_man[0]),
        .o_man     (w_rman),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_dbl    <= '0;
            r_exp    <= '0;
            r_man    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_tiny   <= 1'b0;
            r_bypass <= 1'b0;
            r_float  <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_dbl   <= bus.dbl;
                        r_done  <= 1'b0;
                        r_flags <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_e == F64_EXP_ALL_ONES) begin
                        // NaNs are always returned quiet; the payload keeps its top bits.
                        r_float     <= {w_s, F32_EXP_ALL_ONES,
                                        (w_m == '0) ? 23'd0 : {1'b1, w_m[50:29]}};
                        r_flags.nan <= (w_m != '0) && !w_m[51];
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_e == '0) begin
                        r_float     <= {w_s, 31'd0};
                        r_flags.unf <= |w_m;
                        r_flags.inx <= |w_m;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_state <= ROUND;
                    r_tiny  <= 1'b0;
                    if (w_e32 >= 12'sd255) begin
                        r_float     <= (ROUND_MODE == RM_RNE) ? {w_s, F32_EXP_ALL_ONES, 23'd0}
                                                              : {w_s, 8'hFE, 23'h7FFFFF};
                        r_flags.ovf <= 1'b1;
                        r_flags.inx <= 1'b1;
                        r_bypass    <= 1'b1;
                    end else if (w_e32 <= 12'sd0) begin
`ifdef DOUBLE_TO_FLOAT_SUBNORMAL_EN
                        if (w_sh >= 12'd25) begin
                            r_float     <= {w_s, 31'd0};
                            r_flags.unf <= 1'b1;
                            r_flags.inx <= 1'b1;
                            r_bypass    <= 1'b1;
                        end else begin
                            r_exp    <= '0;
                            r_man    <= w_wide[76:54];
                            r_guard  <= w_wide[53];
                            r_sticky <= |w_wide[52:0];
                            r_tiny   <= 1'b1;
                            r_bypass <= 1'b0;
                        end
`else
                        r_float     <= {w_s, 31'd0};
                        r_flags.unf <= 1'b1;
                        r_flags.inx <= 1'b1;
                        r_bypass    <= 1'b1;
`endif
                    end else begin
                        r_exp    <= w_e32[7:0];
                        r_man    <= w_m[51:29];
                        r_guard  <= w_m[28];
                        r_sticky <= |w_m[27:0];
                        r_bypass <= 1'b0;
                    end
                end
                ROUND: begin
                    // Bypassed results were fully formed in CONVERT; only the handshake advances.
                    if (!r_bypass) begin
                        if (w_carry) begin
                            if (r_exp + 8'd1 == F32_EXP_ALL_ONES) begin
                                r_float     <= {w_s, F32_EXP_ALL_ONES, 23'd0};
                                r_flags.ovf <= 1'b1;
                            end else begin
                                r_float <= {w_s, r_exp + 8'd1, 23'd0};
                            end
                        end else begin
                            r_float <= {w_s, r_exp, w_rman};
                        end
                        r_flags.inx <= w_inexact;
                        r_flags.unf <= r_tiny & w_inexact;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.flt           = r_float;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.nan_exception = r_flags.nan;
    assign bus.overflow      = r_flags.ovf;
    assign bus.underflow     = r_flags.unf;
    assign bus.inexact       = r_flags.inx;
endmodule

// File: tb/tb_double_to_float.sv
// Bench for double_to_float: one RNE and one RTZ instance fed identical operands, checked
// against an arithmetic (quotient/remainder) reference model.
module tb_double_to_float;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    double_to_float_if bus0 ();
    double_to_float_if bus1 ();

    double_to_float #(.ROUND_MODE(0)) dut_rne (.i_clk(clk), .i_reset(rst_n), .bus(bus0));
    double_to_float #(.ROUND_MODE(1)) dut_rtz (.i_clk(clk), .i_reset(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {nan, ovf, unf, inx, float}.
    function automatic logic [35:0] ref_conv(input logic [63:0] d, input int rm);
        logic              s;
        int                e;
        int                e32;
        int                sh;
        logic [51:0]       m;
        longint unsigned   sig, q, r, half;
        logic [31:0]       bits;
        logic              inx, ovf;
        bit                tiny;
        s    = d[63];
        e    = int'(d[62:52]);
        m    = d[51:0];
        tiny = 0;
        ovf  = 1'b0;
        if (e == 2047) begin
            if (m == 0) return {4'b0000, s, 8'hFF, 23'd0};
            return {!m[51], 3'b000, s, 8'hFF, 1'b1, m[50:29]};
        end
        if (e == 0) return {2'b00, m != 0, m != 0, s, 31'd0};
        e32 = e - 896;
        if (e32 >= 255)
            return {4'b0101, (rm == 0) ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF}};
        sh = 29;
        if (e32 <= 0) begin
`ifdef DOUBLE_TO_FLOAT_SUBNORMAL_EN
            if (1 - e32 >= 25) return {4'b0011, s, 31'd0};
            tiny = 1;
            sh   = 29 + 1 - e32;
`else
            return {4'b0011, s, 31'd0};
`endif
        end
        sig  = (64'd1 << 52) | 64'(m);
        q    = sig >> sh;
        r    = sig - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (r != 0);
        if (rm == 0 && (r > half || (r == half && q[0]))) q = q + 1;
        // The significand includes the hidden bit, so adding it lets a carry ripple into the exponent.
        bits = tiny ? q[31:0] : (32'(e32 - 1) << 23) + q[31:0];
        if (bits[30:23] == 8'hFF) ovf = 1'b1;
        return {1'b0, ovf, logic'(tiny && inx), inx, s, bits[30:0]};
    endfunction

    // Pulses start on both DUTs and reports on which posedge (accept edge = 1) done rose.
    task automatic convert(input logic [63:0] d, output int lat0, output int lat1);
        int n;
        @(negedge clk);
        bus0.start = 1'b1; bus0.dbl = d;
        bus1.start = 1'b1; bus1.dbl = d;
        @(posedge clk);
        #1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        n = 1; lat0 = 0; lat1 = 0;
        while ((lat0 == 0 || lat1 == 0) && n < 12) begin
            if (bus0.done && lat0 == 0) lat0 = n;
            if (bus1.done && lat1 == 0) lat1 = n;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.dbl = '0;
        bus1.start = 1'b0; bus1.dbl = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus0.flt, bus0.busy, bus0.done, bus0.nan_exception, bus0.overflow,
             bus0.underflow, bus0.inexact} !== 38'd0) begin
            errs++;
            $display("FAIL reset_rne: got flt=%h busy=%b done=%b want all zero", bus0.flt, bus0.busy, bus0.done);
        end
        checks++;
        if ({bus1.flt, bus1.busy, bus1.done, bus1.nan_exception, bus1.overflow,
             bus1.underflow, bus1.inexact} !== 38'd0) begin
            errs++;
            $display("FAIL reset_rtz: got flt=%h busy=%b done=%b want all zero", bus1.flt, bus1.busy, bus1.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] dv [9];
        logic [31:0] frne [9];
        logic [31:0] frtz [9];
        logic [3:0]  fl [9];
        int          lat [9];
        int          l0, l1;
        dv[0] = 64'h3FF0000000000000; frne[0] = 32'h3F800000; frtz[0] = 32'h3F800000; fl[0] = 4'b0000; lat[0] = 4;
        dv[1] = 64'h3FF0000010000000; frne[1] = 32'h3F800000; frtz[1] = 32'h3F800000; fl[1] = 4'b0001; lat[1] = 4;
        dv[2] = 64'h3FF0000030000000; frne[2] = 32'h3F800002; frtz[2] = 32'h3F800001; fl[2] = 4'b0001; lat[2] = 4;
        dv[3] = 64'h7FF4000000000000; frne[3] = 32'h7FE00000; frtz[3] = 32'h7FE00000; fl[3] = 4'b1000; lat[3] = 2;
        dv[4] = 64'hFFF0000000000000; frne[4] = 32'hFF800000; frtz[4] = 32'hFF800000; fl[4] = 4'b0000; lat[4] = 2;
        dv[5] = 64'h47F0000000000000; frne[5] = 32'h7F800000; frtz[5] = 32'h7F7FFFFF; fl[5] = 4'b0101; lat[5] = 4;
`ifdef DOUBLE_TO_FLOAT_SUBNORMAL_EN
        dv[6] = 64'h36A0000000000000; frne[6] = 32'h00000001; frtz[6] = 32'h00000001; fl[6] = 4'b0000; lat[6] = 4;
`else
        dv[6] = 64'h36A0000000000000; frne[6] = 32'h00000000; frtz[6] = 32'h00000000; fl[6] = 4'b0011; lat[6] = 4;
`endif
        dv[7] = 64'h8000000000000001; frne[7] = 32'h80000000; frtz[7] = 32'h80000000; fl[7] = 4'b0011; lat[7] = 2;
        dv[8] = 64'h7FF8000000000000; frne[8] = 32'h7FC00000; frtz[8] = 32'h7FC00000; fl[8] = 4'b0000; lat[8] = 2;
        for (int i = 0; i < 9; i++) begin
            convert(dv[i], l0, l1);
            checks++;
            if (bus0.flt !== frne[i] || {bus0.nan_exception, bus0.overflow, bus0.underflow, bus0.inexact} !== fl[i]) begin
                errs++;
                $display("FAIL directed_rne[%0d] %h: got %h flags %b want %h flags %b", i, dv[i], bus0.flt,
                         {bus0.nan_exception, bus0.overflow, bus0.underflow, bus0.inexact}, frne[i], fl[i]);
            end
            checks++;
            if (bus1.flt !== frtz[i] || {bus1.nan_exception, bus1.overflow, bus1.underflow, bus1.inexact} !== fl[i]) begin
                errs++;
                $display("FAIL directed_rtz[%0d] %h: got %h flags %b want %h flags %b", i, dv[i], bus1.flt,
                         {bus1.nan_exception, bus1.overflow, bus1.underflow, bus1.inexact}, frtz[i], fl[i]);
            end
            checks++;
            if (l0 != lat[i] || l1 != lat[i]) begin
                errs++;
                $display("FAIL directed_latency[%0d]: got %0d/%0d want %0d", i, l0, l1, lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] d, rnd;
        logic [35:0] exp0, exp1;
        int          e, sel, l0, l1, lexp;
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom(), $urandom()};
            sel = $urandom_range(0, 9);
            case (sel)
                0:       e = 2047;
                1:       e = 0;
                2, 3:    e = $urandom_range(860, 900);
                4, 5:    e = $urandom_range(1140, 1160);
                default: e = $urandom_range(1, 2046);
            endcase
            d = {rnd[63], 11'(e), rnd[51:0]};
            if (sel == 6) d[28:0] = 29'h10000000;
            if (sel == 7) d[51:28] = '1;
            if (sel == 8) d = {rnd[63], 11'd1150, 23'h7FFFFF, 1'b1, rnd[27:0]};
            exp0 = ref_conv(d, 0);
            exp1 = ref_conv(d, 1);
            lexp = (e == 0 || e == 2047) ? 2 : 4;
            convert(d, l0, l1);
            checks++;
            if ({bus0.nan_exception, bus0.overflow, bus0.underflow, bus0.inexact, bus0.flt} !== exp0) begin
                errs++;
                $display("FAIL random_rne %h: got %b_%h want %b_%h", d,
                         {bus0.nan_exception, bus0.overflow, bus0.underflow, bus0.inexact}, bus0.flt, exp0[35:32], exp0[31:0]);
            end
            checks++;
            if ({bus1.nan_exception, bus1.overflow, bus1.underflow, bus1.inexact, bus1.flt} !== exp1) begin
                errs++;
                $display("FAIL random_rtz %h: got %b_%h want %b_%h", d,
                         {bus1.nan_exception, bus1.overflow, bus1.underflow, bus1.inexact}, bus1.flt, exp1[35:32], exp1[31:0]);
            end
            checks++;
            if (l0 != lexp || l1 != lexp) begin
                errs++;
                $display("FAIL random_latency %h: got %0d/%0d want %0d", d, l0, l1, lexp);
            end
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        bus0.start = 1'b1; bus0.dbl = 64'h3FF0000000000000;
        bus1.start = 1'b1; bus1.dbl = 64'h3FF0000000000000;
        @(posedge clk);
        #1;
        bus0.dbl = 64'h4000000000000000; bus1.dbl = 64'h4000000000000000;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
            errs++;
            $display("FAIL busy_flag: got busy=%b done=%b want busy=1 done=0", bus0.busy, bus0.done);
        end
        @(posedge clk);
        #1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.done !== 1'b1 || bus0.flt !== 32'h3F800000 || bus1.flt !== 32'h3F800000) begin
            errs++;
            $display("FAIL start_ignored: got done=%b flt=%h/%h want done=1 flt=3f800000", bus0.done, bus0.flt, bus1.flt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus0.start = 1'b1; bus0.dbl = 64'h3FF0000030000000;
        bus1.start = 1'b1; bus1.dbl = 64'h3FF0000030000000;
        @(posedge clk);
        #1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.flt !== 32'd0 ||
            bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.flt !== 32'd0) begin
            errs++;
            $display("FAIL reset_mid: got busy=%b done=%b flt=%h want busy=0 done=0 flt=0", bus0.busy, bus0.done, bus0.flt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_abort: got busy=%b done=%b want 0/0", bus0.busy, bus0.done);
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
